// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between instruction fetch (imem) and the
// memory stage (dmem). One transaction is outstanding at a time. Simultaneous
// requests are resolved round-robin, and the response is steered back to the
// owning port in the same cycle the memory answers.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   imem_req_i/addr_i             fetch read request (held until imem_resp_o)
//   imem_rdata_o/resp_o           fetch read data and one-cycle completion
//   dmem_req_i/we_i/wmask_i       data request, store enable, byte enables
//   dmem_addr_i/wdata_i           data address and store data
//   dmem_rdata_o/resp_o           load data and one-cycle completion
//   mem_req_o/we_o/wmask_o        downstream request (held until mem_resp_i)
//   mem_addr_o/wdata_o            downstream address and write data
//   mem_rdata_i/resp_i            downstream read data and completion
module mem_arbiter #(
    parameter int XLEN  = 32,
    parameter int ADDRW = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                imem_req_i,
    input  logic [ADDRW-1:0]    imem_addr_i,
    output logic [XLEN-1:0]     imem_rdata_o,
    output logic                imem_resp_o,
    input  logic                dmem_req_i,
    input  logic                dmem_we_i,
    input  logic [XLEN/8-1:0]   dmem_wmask_i,
    input  logic [ADDRW-1:0]    dmem_addr_i,
    input  logic [XLEN-1:0]     dmem_wdata_i,
    output logic [XLEN-1:0]     dmem_rdata_o,
    output logic                dmem_resp_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_wmask_o,
    output logic [ADDRW-1:0]    mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic [XLEN-1:0]     mem_rdata_i,
    input  logic                mem_resp_i
);

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { PORT_IMEM, PORT_DMEM } port_t;

    state_t state;
    port_t  owner;
    port_t  last_grant;
    port_t  grant_port;

    // Port that wins if the arbiter grants this cycle. On a conflict the port
    // that did not win last time is chosen, so neither side can starve.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        grant_port = PORT_IMEM;
        if (dmem_req_i && (!imem_req_i || last_grant == PORT_IMEM)) begin
            grant_port = PORT_DMEM;
        end
    end

    // The downstream fields are captured at grant and held for the whole
    // transaction, so the memory sees a stable request even if a requester
    // misbehaves and changes its inputs mid-transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state       <= IDLE;
            owner       <= PORT_IMEM;
            last_grant  <= PORT_IMEM;
            mem_we_o    <= 1'b0;
            mem_wmask_o <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imem_req_i || dmem_req_i) begin
                        state      <= BUSY;
                        owner      <= grant_port;
                        last_grant <= grant_port;
                        if (grant_port == PORT_DMEM) begin
                            mem_we_o    <= dmem_we_i;
                            mem_wmask_o <= dmem_wmask_i;
                            mem_addr_o  <= dmem_addr_i;
                            mem_wdata_o <= dmem_wdata_i;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_wmask_o <= '0;
                            mem_addr_o  <= imem_addr_i;
                            mem_wdata_o <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Requests arriving now are only looked at in the next
                    // IDLE cycle, which costs one bubble per transaction.
                    if (mem_resp_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_req_o is a decode of the state flop, so it is glitch-free and
    // drops in the cycle after the response.
    assign mem_req_o = (state == BUSY);

    // Responses are combinational from mem_resp_i so the memory stage sees
    // its completion in the same cycle the memory answers. A response while
    // IDLE matches no owner and is dropped.
    assign imem_resp_o = (state == BUSY) && (owner == PORT_IMEM) && mem_resp_i;
    assign dmem_resp_o = (state == BUSY) && (owner == PORT_DMEM) && mem_resp_i;

    assign imem_rdata_o = mem_rdata_i;
    assign dmem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int XLEN  = 32;
    localparam int ADDRW = 32;
    localparam int MW    = XLEN / 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             imem_req_i;
    logic [ADDRW-1:0] imem_addr_i;
    logic [XLEN-1:0]  imem_rdata_o;
    logic             imem_resp_o;
    logic             dmem_req_i;
    logic             dmem_we_i;
    logic [MW-1:0]    dmem_wmask_i;
    logic [ADDRW-1:0] dmem_addr_i;
    logic [XLEN-1:0]  dmem_wdata_i;
    logic [XLEN-1:0]  dmem_rdata_o;
    logic             dmem_resp_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic [MW-1:0]    mem_wmask_o;
    logic [ADDRW-1:0] mem_addr_o;
    logic [XLEN-1:0]  mem_wdata_o;
    logic [XLEN-1:0]  mem_rdata_i;
    logic             mem_resp_i;

    mem_arbiter #(.XLEN(XLEN), .ADDRW(ADDRW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .imem_req_i   (imem_req_i),
        .imem_addr_i  (imem_addr_i),
        .imem_rdata_o (imem_rdata_o),
        .imem_resp_o  (imem_resp_o),
        .dmem_req_i   (dmem_req_i),
        .dmem_we_i    (dmem_we_i),
        .dmem_wmask_i (dmem_wmask_i),
        .dmem_addr_i  (dmem_addr_i),
        .dmem_wdata_i (dmem_wdata_i),
        .dmem_rdata_o (dmem_rdata_o),
        .dmem_resp_o  (dmem_resp_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_resp_i   (mem_resp_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: the transaction currently on the bus (if any) and
    // which port won the most recent grant.
    bit        m_busy;
    bit        m_owner_dmem;
    bit        m_last_dmem;
    bit [31:0] m_addr;
    bit        m_we;
    bit [3:0]  m_wmask;
    bit [31:0] m_wdata;

    // Memory responder: answers after mem_lat stall cycles.
    int  wait_cnt   = 0;
    int  mem_lat    = 0;
    bit  auto_mem   = 1'b1;
    bit  rand_lat   = 1'b0;
    bit  spurious   = 1'b0;
    bit  rand_rdata = 1'b1;
    bit [31:0] fixed_rdata = 32'h0;
    int  cyc = 0;

    // Expected/observed results of the most recent cycle.
    bit exp_iresp, exp_dresp;
    bit obs_iresp, obs_dresp, obs_req;
    bit [31:0] obs_addr, obs_rdata;

    typedef struct {
        bit        pend;
        bit [31:0] addr;
        bit        we;
        bit [3:0]  mask;
        bit [31:0] wdata;
    } rq_t;

    rq_t ip, dp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy       = 1'b0;
        m_owner_dmem = 1'b0;
        m_last_dmem  = 1'b0;
        m_addr       = '0;
        m_we         = 1'b0;
        m_wmask      = '0;
        m_wdata      = '0;
        wait_cnt     = 0;
    endtask

    // One clock cycle: settle inputs, compare outputs mid-cycle, then advance
    // the model across the rising edge.
    task automatic cycle();
        bit both;
        bit to_dmem;
        if (auto_mem) begin
            mem_resp_i = m_busy ? (wait_cnt == mem_lat) : (spurious && ($urandom_range(3) == 0));
        end
        mem_rdata_i = rand_rdata ? $urandom() : fixed_rdata;
        #1;
        exp_iresp = m_busy && !m_owner_dmem && mem_resp_i;
        exp_dresp = m_busy &&  m_owner_dmem && mem_resp_i;
        check("mem_req",   32'(mem_req_o),   32'(m_busy));
        check("imem_resp", 32'(imem_resp_o), 32'(exp_iresp));
        check("dmem_resp", 32'(dmem_resp_o), 32'(exp_dresp));
        check("resp_excl", 32'(imem_resp_o & dmem_resp_o), 32'd0);
        if (m_busy) begin
            check("mem_addr",  32'(mem_addr_o),  m_addr);
            check("mem_we",    32'(mem_we_o),    32'(m_we));
            check("mem_wmask", 32'(mem_wmask_o), 32'(m_wmask));
            check("mem_wdata", 32'(mem_wdata_o), m_wdata);
        end
        if (exp_iresp) check("imem_rdata", imem_rdata_o, mem_rdata_i);
        if (exp_dresp) check("dmem_rdata", dmem_rdata_o, mem_rdata_i);
        obs_iresp = imem_resp_o;
        obs_dresp = dmem_resp_o;
        obs_req   = mem_req_o;
        obs_addr  = mem_addr_o;
        obs_rdata = imem_resp_o ? imem_rdata_o : dmem_rdata_o;
        @(posedge clk_i);
        if (rst_i) begin
            model_reset();
        end else if (m_busy) begin
            if (mem_resp_i) begin
                m_busy   = 1'b0;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else if (imem_req_i || dmem_req_i) begin
            both    = imem_req_i && dmem_req_i;
            to_dmem = both ? !m_last_dmem : dmem_req_i;
            m_busy       = 1'b1;
            m_owner_dmem = to_dmem;
            m_last_dmem  = to_dmem;
            m_addr       = to_dmem ? dmem_addr_i  : imem_addr_i;
            m_we         = to_dmem ? dmem_we_i    : 1'b0;
            m_wmask      = to_dmem ? dmem_wmask_i : 4'h0;
            m_wdata      = to_dmem ? dmem_wdata_i : 32'h0;
            wait_cnt     = 0;
            if (rand_lat) mem_lat = $urandom_range(3);
        end
        cyc++;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   32'(mem_req_o),   32'd0);
        check({tag, "_we"},    32'(mem_we_o),    32'd0);
        check({tag, "_wmask"}, 32'(mem_wmask_o), 32'd0);
        check({tag, "_addr"},  32'(mem_addr_o),  32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata_o), 32'd0);
        check({tag, "_iresp"}, 32'(imem_resp_o), 32'd0);
        check({tag, "_dresp"}, 32'(dmem_resp_o), 32'd0);
    endtask

    initial begin : stimulus
        int req_cnt, ir_cnt, dr_cnt, resp_at, req_start;
        bit [31:0] got_rdata;
        int obs_code [8];
        int exp_code [8];
        bit req_at  [16];
        bit [31:0] addr_at [16];
        int dresp_cyc, iresp_cyc;

        rst_i        = 1'b1;
        imem_req_i   = 1'b0;
        imem_addr_i  = '0;
        dmem_req_i   = 1'b0;
        dmem_we_i    = 1'b0;
        dmem_wmask_i = '0;
        dmem_addr_i  = '0;
        dmem_wdata_i = '0;
        mem_rdata_i  = '0;
        mem_resp_i   = 1'b0;
        model_reset();

        // Reset state.
        cycle();
        cycle();
        rst_i = 1'b0;
        check_reset_outputs("reset");

        // imem only, one stall cycle, fixed read data.
        mem_lat = 1;
        rand_rdata = 1'b0;
        fixed_rdata = 32'h0000_0013;
        imem_req_i = 1'b1;
        imem_addr_i = 32'h0000_0100;
        req_cnt = 0; ir_cnt = 0; dr_cnt = 0; got_rdata = '0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (obs_req) req_cnt++;
            if (obs_dresp) dr_cnt++;
            if (obs_iresp) begin
                ir_cnt++;
                got_rdata = obs_rdata;
                imem_req_i = 1'b0;
            end
        end
        check("imem_req_cycles", 32'(req_cnt), 32'd2);
        check("imem_resp_count", 32'(ir_cnt), 32'd1);
        check("imem_no_dresp", 32'(dr_cnt), 32'd0);
        check("imem_rdata_val", got_rdata, 32'h0000_0013);
        rand_rdata = 1'b1;

        // dmem store, zero-wait.
        mem_lat = 0;
        dmem_req_i = 1'b1;
        dmem_we_i = 1'b1;
        dmem_addr_i = 32'h8000_0004;
        dmem_wdata_i = 32'hDEAD_BEEF;
        dmem_wmask_i = 4'b1100;
        resp_at = -1; req_start = -1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (obs_req && req_start < 0) begin
                req_start = k;
                check("st_addr",  mem_addr_o,  32'h8000_0004);
                check("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
                check("st_wmask", 32'(mem_wmask_o), 32'hC);
                check("st_we",    32'(mem_we_o), 32'd1);
            end
            if (obs_dresp) begin
                resp_at = k;
                dmem_req_i = 1'b0;
                dmem_we_i  = 1'b0;
            end
        end
        check("st_req_start", 32'(req_start), 32'd1);
        check("st_resp_cycle", 32'(resp_at), 32'd1);

        // Both ports requesting continuously from reset.
        imem_addr_i = 32'h0000_0200;
        dmem_addr_i = 32'h0000_0300;
        dmem_we_i = 1'b0;
        imem_req_i = 1'b1;
        dmem_req_i = 1'b1;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        exp_code = '{0, 2, 0, 1, 0, 2, 0, 1};
        for (int k = 0; k < 8; k++) begin
            cycle();
            obs_code[k] = (obs_iresp ? 1 : 0) + (obs_dresp ? 2 : 0);
        end
        for (int k = 0; k < 8; k++) check($sformatf("rr_slot%0d", k), 32'(obs_code[k]), 32'(exp_code[k]));
        imem_req_i = 1'b0;
        dmem_req_i = 1'b0;
        cycle();

        // dmem load with a 5-cycle stall; imem arrives mid-wait.
        mem_lat = 5;
        dmem_req_i = 1'b1;
        dmem_we_i = 1'b0;
        dmem_addr_i = 32'h1234_5678;
        dmem_wdata_i = 32'h5555_AAAA;
        imem_addr_i = 32'h0000_0400;
        dresp_cyc = -1; iresp_cyc = -1;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) imem_req_i = 1'b1;
            cycle();
            req_at[k] = obs_req;
            addr_at[k] = obs_addr;
            if (obs_dresp) begin dresp_cyc = k; dmem_req_i = 1'b0; end
            if (obs_iresp) begin iresp_cyc = k; imem_req_i = 1'b0; end
        end
        check("stall_dresp_cycle", 32'(dresp_cyc), 32'd6);
        check("stall_gap_idle", 32'(req_at[7]), 32'd0);
        check("stall_imem_addr", addr_at[8], 32'h0000_0400);
        check("stall_iresp_cycle", 32'(iresp_cyc), 32'd13);

        // Spurious memory response while idle.
        auto_mem = 1'b0;
        mem_resp_i = 1'b1;
        ir_cnt = 0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            if (obs_iresp || obs_dresp) ir_cnt++;
        end
        check("spur_no_resp", 32'(ir_cnt), 32'd0);
        check("spur_idle", 32'(mem_req_o), 32'd0);
        mem_resp_i = 1'b0;
        auto_mem = 1'b1;

        // Reset in the 3rd BUSY cycle of a 10-cycle stall.
        mem_lat = 10;
        imem_req_i = 1'b1;
        imem_addr_i = 32'h0000_0500;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                rst_i = 1'b1;
                imem_req_i = 1'b0;
            end
            cycle();
        end
        rst_i = 1'b0;
        check_reset_outputs("midrst");
        auto_mem = 1'b0;
        mem_resp_i = 1'b1;
        cycle();
        check("late_resp_i", 32'(obs_iresp), 32'd0);
        check("late_resp_d", 32'(obs_dresp), 32'd0);
        mem_resp_i = 1'b0;
        auto_mem = 1'b1;

        // Randomized traffic with random latency and spurious responses.
        rand_lat = 1'b1;
        spurious = 1'b1;
        mem_lat = 0;
        ip = '{pend: 1'b0, addr: 32'h0, we: 1'b0, mask: 4'h0, wdata: 32'h0};
        dp = ip;
        for (int k = 0; k < 400; k++) begin
            if (!ip.pend && $urandom_range(1) == 1) begin
                ip.pend = 1'b1;
                ip.addr = $urandom();
            end
            if (!dp.pend && $urandom_range(1) == 1) begin
                dp.pend  = 1'b1;
                dp.addr  = $urandom();
                dp.we    = 1'($urandom_range(1));
                dp.mask  = 4'($urandom_range(15));
                dp.wdata = $urandom();
            end
            imem_req_i   = ip.pend;
            imem_addr_i  = ip.addr;
            dmem_req_i   = dp.pend;
            dmem_addr_i  = dp.addr;
            dmem_we_i    = dp.we;
            dmem_wmask_i = dp.mask;
            dmem_wdata_i = dp.wdata;
            cycle();
            if (exp_iresp) ip.pend = 1'b0;
            if (exp_dresp) dp.pend = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
